// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_entry_t : {pc, inst} pair at the default 32-bit width
//   fetch_state_t : RUN (normal) / DRAIN (stale responses still owed by memory)
//   PC_INC        : sequential PC step
//   RESET_PC_DEF / EXC_VECTOR_DEF : default reset PC and exception vector
package fetch_pkg;

    localparam int          FETCH_XLEN     = 32;
    localparam int          PC_INC         = 4;
    localparam logic [31:0] RESET_PC_DEF   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0080;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both as the fetch buffer and as the in-order
// PC tag queue of outstanding memory requests.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : empties the FIFO (wins over push/pop)
//   push, push_data   : write one entry
//   pop               : drop the head entry
//   head              : current head entry (combinational read)
//   count             : number of valid entries (0..DEPTH)
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count_reg != CW'(DEPTH));
    assign do_pop  = pop  && !flush && (count_reg != '0);

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues pipelined requests to
// instruction memory, buffers returned {pc, inst} pairs and hands them to
// decode over a valid/ready handshake. Redirects (except > br_taken > jmp)
// flush the buffer and turn every outstanding request into a kill that
// discards its response when it returns.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   br_taken/br_target             : taken branch pulse and target
//   jmp/jmp_target                 : jump pulse and target
//   except                         : exception pulse (goes to EXC_VECTOR)
//   imem_req/imem_addr/imem_gnt    : request channel (addr is the PC)
//   imem_rvalid/imem_rdata         : in-order response channel
//   if_valid/if_ready/if_pc/if_inst: decode handshake, FIFO head
//   if_addr_err                    : only with FETCH_ALIGN_CHK_EN defined;
//                                    one-cycle pulse after a misaligned
//                                    branch/jump target was replaced by
//                                    EXC_VECTOR
// Build option: FETCH_ALIGN_CHK_EN (undefined: targets have bits [1:0]
// forced to zero).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            except,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
`ifdef FETCH_ALIGN_CHK_EN
    output logic            if_addr_err,
`endif
    output logic [XLEN-1:0] if_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [CW-1:0]   kill_reg, kill_next;
    fetch_state_t    state_reg;

    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   tag_count;
    entry_t          buf_head;
    entry_t          buf_push_data;
    logic [XLEN-1:0] tag_head;

    logic            redirect;
    logic            grant;
    logic            drop_rsp;
    logic            accept_rsp;
    logic            buf_pop;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] redirect_pc;
    logic [CW:0]     occupancy;

    assign redirect   = except | br_taken | jmp;
    assign raw_target = br_taken ? br_target : jmp_target;

`ifdef FETCH_ALIGN_CHK_EN
    logic misaligned;
    logic addr_err_reg;

    // A misaligned branch/jump is never fetched; it becomes an exception.
    assign misaligned  = !except && (br_taken || jmp) && (raw_target[1:0] != 2'b00);
    assign redirect_pc = (except || misaligned) ? EXC_VECTOR : raw_target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= misaligned;
        end
    end

    assign if_addr_err = addr_err_reg;
`else
    assign redirect_pc = except ? EXC_VECTOR : (raw_target & ~XLEN'(3));
`endif

    assign drop_rsp   = (state_reg == DRAIN);
    assign accept_rsp = imem_rvalid && !drop_rsp && !redirect;
    assign if_valid   = (buf_count != '0);
    assign buf_pop    = if_valid && if_ready;

    // The tag queue holds exactly the live (non-killed) requests in flight,
    // so its count doubles as the inflight counter. An entry leaving the
    // buffer this cycle frees its slot, which keeps a 1/cycle stream going.
    assign occupancy = {1'b0, buf_count} + {1'b0, tag_count} + {1'b0, kill_reg}
                     - {{CW{1'b0}}, buf_pop};
    assign imem_req  = rst_n && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc_reg;
    assign grant     = imem_req && imem_gnt;

    assign buf_push_data = '{pc: tag_head, inst: imem_rdata};

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (grant),
        .push_data (pc_reg),
        .pop       (accept_rsp),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (accept_rsp),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign if_pc   = if_valid ? buf_head.pc   : '0;
    assign if_inst = if_valid ? buf_head.inst : '0;

    // On a redirect every live request becomes a kill; a response landing in
    // the same cycle already settles one of them.
    always_comb begin
        pc_next   = pc_reg;
        kill_next = kill_reg;
        if (redirect) begin
            pc_next   = redirect_pc;
            kill_next = kill_reg + tag_count + CW'(grant) - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                pc_next = pc_reg + XLEN'(PC_INC);
            end
            if (imem_rvalid && drop_rsp) begin
                kill_next = kill_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            kill_reg  <= '0;
            state_reg <= RUN;
        end else begin
            pc_reg    <= pc_next;
            kill_reg  <= kill_next;
            state_reg <= (kill_next != '0) ? DRAIN : RUN;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage, the first stage of the MIPS pipeline.
- Holds the PC and selects the next PC: sequential, branch, jump or exception vector, with fixed priority.
- Issues pipelined requests to instruction memory and buffers returned {pc, inst} pairs in a small FIFO.
- Hands instructions to decode over a valid/ready handshake and discards stale responses after a redirect.

Parameters:
- XLEN, 32, PC/address/instruction width.
- DEPTH, 2, fetch-buffer entries; also the maximum number of requests in flight. Power of two, 2..8.
- RESET_PC, 32'hBFC0_0000, PC loaded at reset.
- EXC_VECTOR, 32'h8000_0080, exception target PC.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- br_taken  in  1  branch resolved taken (one-cycle pulse)
- br_target  in  XLEN  branch target
- jmp  in  1  jump (one-cycle pulse)
- jmp_target  in  XLEN  jump target
- except  in  1  exception (one-cycle pulse)
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address (equals the PC)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant
- imem_rdata  in  XLEN  instruction word
- if_valid  out  1  buffer head valid
- if_ready  in  1  decode accepts the head
- if_pc  out  XLEN  PC of the head
- if_inst  out  XLEN  instruction of the head

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc=RESET_PC; FIFO empty; inflight=0; kill=0.
  - imem_req=0, if_valid=0, if_pc=0, if_inst=0.
  - A reset during an in-flight request abandons it. The memory side must also be reset, so no kill is kept.
- Request issue:
  - imem_req=1 when rst_n=1, no redirect this cycle, and fifo_count+inflight < DEPTH.
  - imem_addr=pc.
  - On req && gnt: pc <= pc+4 (mod 2^XLEN; wraps at 32'hFFFF_FFFC to 0), inflight++, and the PC is pushed onto an internal in-order tag queue.
- Response:
  - On imem_rvalid, if kill>0: kill-- and the data is dropped.
  - Otherwise: push {tagged pc, imem_rdata} into the FIFO and inflight--.
  - Space is guaranteed by the request rule, so the FIFO never overflows.
  - Simultaneous grant and response in one cycle: inflight is unchanged.
- Output:
  - if_valid = FIFO non-empty; if_pc/if_inst show the FIFO head.
  - Pop on if_valid && if_ready.
  - Latency: grant at cycle N, rvalid at N+1, if_valid at N+2. Full throughput is 1 instruction/cycle.
- Redirect priority: except > br_taken > jmp.
  - Target is EXC_VECTOR / br_target / jmp_target.
  - On any redirect: pc <= target; FIFO flushed; tag queue cleared.
  - kill <= kill + inflight (+1 if a grant occurs the same cycle; that grant still counts), then inflight <= 0.
  - imem_req=0 in the redirect cycle. The first request to the target issues the following cycle.
  - A response arriving in the redirect cycle decrements the kill total.
- Request gating while kill>0: new requests are allowed, but only if fifo_count+inflight+kill < DEPTH.
- State machine:
  - RUN: normal operation.
  - DRAIN: kill>0. Responses are discarded. Return to RUN when kill reaches 0.
  - Reset enters RUN.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - Adds output if_addr_err (1 bit, reset 0).
  - If a branch or jump target has [1:0]!=0, the redirect goes to EXC_VECTOR instead.
  - if_addr_err pulses high for 1 cycle; the bad address is not fetched.
- Undefined:
  - Targets are used as-is with bits [1:0] forced to 0.
  - No if_addr_err port.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {pc, inst}.
  - enum fetch_state_t {RUN, DRAIN}.
  - constants PC_INC=4, default RESET_PC and EXC_VECTOR.
- Sub-module fetch_fifo: parametrised DEPTH×fetch_entry_t synchronous FIFO with push, pop, flush and count.
- Reused twice: as the instruction buffer and as the PC tag queue.

Test Plan:
- Reset release with gnt=1 and 1-cycle memory, if_ready=1 → imem_addr sequence BFC00000, BFC00004, …; if_valid from cycle 2; one instruction per cycle.
- if_ready=0 for 5 cycles, DEPTH=2 → imem_req drops after 2 grants; no overflow; order preserved on release.
- 2 requests in flight, br_taken to 0x00400100 → both stale responses dropped; the next if_pc is 0x00400100.
- except and br_taken in the same cycle → pc=80000080 (exception wins).
- PC at FFFFFFFC granted → next imem_addr is 00000000.
- FETCH_ALIGN_CHK_EN defined, jmp_target=0x00400102 → if_addr_err pulses once; next fetch is at 80000080.
